// File: rtl/fc_mac_pkg.sv
// ---------------------------------------------------------------------------
// fc_mac_pkg
// Shared constants for the FC-layer multiply-accumulate engine: default
// operand/accumulator/result widths and the helpers that derive the signed
// saturation limits of the result from its width.
// No ports (package).
// ---------------------------------------------------------------------------
package fc_mac_pkg;

  localparam int FC_DIN0_WIDTH = 16;
  localparam int FC_DIN1_WIDTH = 16;
  localparam int FC_NUM_STAGE  = 3;
  localparam int FC_ACC_WIDTH  = 40;
  localparam int FC_OUT_WIDTH  = 32;

  // Limits are computed wide enough for any practical accumulator width and
  // then narrowed by the caller to its own accumulator width.
  localparam int FC_LIMIT_WIDTH = 128;

  // Largest value representable in a signed out_width-bit result.
  function automatic logic signed [FC_LIMIT_WIDTH-1:0] fc_sat_max(input int out_width);
    logic signed [FC_LIMIT_WIDTH-1:0] one_v;
    one_v = 128'sd1;
    return (one_v <<< (out_width - 1)) - 128'sd1;
  endfunction

  // Smallest value representable in a signed out_width-bit result (-max-1).
  function automatic logic signed [FC_LIMIT_WIDTH-1:0] fc_sat_min(input int out_width);
    return ~fc_sat_max(out_width);
  endfunction

endpackage

// File: rtl/fc_mac_mul_pipe.sv
// ---------------------------------------------------------------------------
// fc_mac_mul_pipe
// NUM_STAGE-deep signed multiplier. The full-width product and its sideband
// (valid/first/last) travel together through a shift register that freezes
// when ce is low. The first register captures the product directly, so the
// structure maps onto DSP multiplier/pipeline registers.
// Ports:
//   ap_clk, ap_rst_n      clock, asynchronous active-low reset
//   ce                    clock enable, 0 holds every register
//   in_valid/first/last   input beat sideband
//   din0, din1            signed operands
//   pipe_valid/first/last sideband leaving the last stage
//   pipe_prod             signed product leaving the last stage
// ---------------------------------------------------------------------------
module fc_mac_mul_pipe
  import fc_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = FC_DIN0_WIDTH,
  parameter int DIN1_WIDTH = FC_DIN1_WIDTH,
  parameter int NUM_STAGE  = FC_NUM_STAGE
) (
  input  logic                                      ap_clk,
  input  logic                                      ap_rst_n,
  input  logic                                      ce,
  input  logic                                      in_valid,
  input  logic [DIN0_WIDTH-1:0]                     din0,
  input  logic [DIN1_WIDTH-1:0]                     din1,
  input  logic                                      first,
  input  logic                                      last,
  output logic                                      pipe_valid,
  output logic                                      pipe_first,
  output logic                                      pipe_last,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0]   pipe_prod
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  logic signed [PW-1:0]  a_ext;
  logic signed [PW-1:0]  b_ext;
  logic signed [PW-1:0]  mul_res;
  logic signed [PW-1:0]  prod_d [NUM_STAGE];
  logic signed [PW-1:0]  prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  valid_d, valid_q;
  logic [NUM_STAGE-1:0]  first_d, first_q;
  logic [NUM_STAGE-1:0]  last_d,  last_q;

  // Multiply and next-state of the product/sideband shift register.
  always_comb begin
    // Sign-extend both operands to the product width; the truncated
    // PW x PW product is then the exact signed product.
    a_ext   = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
    b_ext   = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
    mul_res = a_ext * b_ext;
    prod_d  = prod_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    if (ce) begin
      prod_d[0]  = mul_res;
      valid_d[0] = in_valid;
      first_d[0] = first;
      last_d[0]  = last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_d[i]  = prod_q[i-1];
        valid_d[i] = valid_q[i-1];
        first_d[i] = first_q[i-1];
        last_d[i]  = last_q[i-1];
      end
    end else begin
      prod_d  = prod_q;
      valid_d = valid_q;
      first_d = first_q;
      last_d  = last_q;
    end
  end

  // Pipeline registers; reset drops every in-flight product.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= {PW{1'b0}};
      end
      valid_q <= {NUM_STAGE{1'b0}};
      first_q <= {NUM_STAGE{1'b0}};
      last_q  <= {NUM_STAGE{1'b0}};
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign pipe_prod  = prod_q[NUM_STAGE-1];
  assign pipe_valid = valid_q[NUM_STAGE-1];
  assign pipe_first = first_q[NUM_STAGE-1];
  assign pipe_last  = last_q[NUM_STAGE-1];

endmodule

// File: rtl/fc_mac_pipe.sv
// ---------------------------------------------------------------------------
// fc_mac_pipe
// Pipelined signed multiply-accumulate for the FC layer. Products from
// fc_mac_mul_pipe are summed over a frame delimited by first/last; one
// saturated result is emitted per frame, NUM_STAGE+1 enabled cycles after
// the last beat.
// Build option: define FC_MAC_RELU_EN to clamp negative results to zero
// after saturation (sat still reports only the saturation clamp).
// Ports:
//   ap_clk, ap_rst_n  clock, asynchronous active-low reset
//   ce                clock enable, 0 holds every register incl. out_valid
//   in_valid          din0/din1/first/last valid this beat
//   din0, din1        signed activation / weight
//   first, last       frame delimiters
//   out_valid         one enabled-cycle pulse, dout/sat valid
//   dout              saturated signed frame sum
//   sat               dout was clamped
// ---------------------------------------------------------------------------
module fc_mac_pipe
  import fc_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = FC_DIN0_WIDTH,
  parameter int DIN1_WIDTH = FC_DIN1_WIDTH,
  parameter int NUM_STAGE  = FC_NUM_STAGE,
  parameter int ACC_WIDTH  = FC_ACC_WIDTH,
  parameter int OUT_WIDTH  = FC_OUT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  first,
  input  logic                  last,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  sat
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(fc_sat_max(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(fc_sat_min(OUT_WIDTH));

  logic                        pipe_valid, pipe_first, pipe_last;
  logic signed [PW-1:0]        pipe_prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic [OUT_WIDTH-1:0]        clamp_val;
  logic                        clamp_hit;
  logic [OUT_WIDTH-1:0]        res_val;
  logic                        out_valid_d, out_valid_q;
  logic [OUT_WIDTH-1:0]        dout_d, dout_q;
  logic                        sat_d, sat_q;

  fc_mac_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul_pipe (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ce         (ce),
    .in_valid   (in_valid),
    .din0       (din0),
    .din1       (din1),
    .first      (first),
    .last       (last),
    .pipe_valid (pipe_valid),
    .pipe_first (pipe_first),
    .pipe_last  (pipe_last),
    .pipe_prod  (pipe_prod)
  );

  // Accumulate, saturate, optional ReLU and output next-state.
  always_comb begin
    prod_ext = ACC_WIDTH'(pipe_prod);
    // A first beat restarts the sum, which also silently drops any frame
    // that never saw its last beat. Addition wraps at ACC_WIDTH.
    if (pipe_valid) begin
      if (pipe_first) begin
        acc_next = prod_ext;
      end else begin
        acc_next = acc_q + prod_ext;
      end
    end else begin
      acc_next = acc_q;
    end

    if (acc_next > SAT_MAX) begin
      clamp_val = SAT_MAX[OUT_WIDTH-1:0];
      clamp_hit = 1'b1;
    end else if (acc_next < SAT_MIN) begin
      clamp_val = SAT_MIN[OUT_WIDTH-1:0];
      clamp_hit = 1'b1;
    end else begin
      clamp_val = acc_next[OUT_WIDTH-1:0];
      clamp_hit = 1'b0;
    end

`ifdef FC_MAC_RELU_EN
    if (clamp_val[OUT_WIDTH-1]) begin
      res_val = {OUT_WIDTH{1'b0}};
    end else begin
      res_val = clamp_val;
    end
`else
    res_val = clamp_val;
`endif

    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    if (ce) begin
      acc_d       = acc_next;
      out_valid_d = pipe_valid & pipe_last;
      if (pipe_valid & pipe_last) begin
        dout_d = res_val;
        sat_d  = clamp_hit;
      end else begin
        dout_d = dout_q;
        sat_d  = sat_q;
      end
    end else begin
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
    end
  end

  // Accumulator and registered outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= {ACC_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      dout_q      <= {OUT_WIDTH{1'b0}};
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule

// File: doc/fc_mac_pipe.md
Name: fc_mac_pipe

Overview:
Pipelined, parametrised signed multiply-accumulate engine for the FC layer. It replaces the single-cycle 16x16 combinational multiplier. It accepts one weight/activation pair per beat. Products pass through a configurable pipeline and are summed over a dot-product frame delimited by first/last flags. One saturated result is emitted per frame, and the block sits between the weight/feature buffers and the FC output writer.

Parameters:
DIN0_WIDTH, 16, signed width of operand din0 (activation)
DIN1_WIDTH, 16, signed width of operand din1 (weight)
NUM_STAGE, 3, multiplier pipeline depth in registers (>=1)
ACC_WIDTH, 40, signed accumulator width (>= DIN0_WIDTH+DIN1_WIDTH)
OUT_WIDTH, 32, signed result width (<= ACC_WIDTH)

Ports:
ap_clk  input  1  clock, all state on rising edge
ap_rst_n  input  1  asynchronous active-low reset
ce  input  1  clock enable; 0 freezes every register in the block
in_valid  input  1  din0/din1/first/last are valid this beat
din0  input  DIN0_WIDTH  signed operand A
din1  input  DIN1_WIDTH  signed operand B
first  input  1  beat is first term of a frame (accumulator loads, does not add)
last  input  1  beat is final term of a frame (result emitted)
out_valid  output  1  one-beat pulse: dout/sat valid
dout  output  OUT_WIDTH  saturated signed frame sum
sat  output  1  dout was clamped this result

Behaviour:
- Reset: all pipeline valid bits, the accumulator, out_valid, dout and sat are 0. Reset is asynchronous assert and is released on a clock edge. Reset mid-frame discards the partial sum and any in-flight products.
- Multiplier: product = signed(din0) * signed(din1), full width DIN0_WIDTH+DIN1_WIDTH. It is registered through NUM_STAGE stages, and each stage carries valid, first and last alongside.
- Accumulate stage (one register): when the pipe-out is valid and first is set, acc = sext(prod). When it is valid and first is clear, acc = acc + sext(prod), wrapping two's complement at ACC_WIDTH. When the pipe-out is invalid, acc holds.
- first and last on the same beat form a single-term frame, so the result equals the product.
- first asserted again without a preceding last restarts the frame, and the old partial sum is dropped silently.
- last without any prior first accumulates onto the current acc. This is undefined usage, but the block must not hang.
- Output: on the beat after the accumulate stage consumes a valid last, out_valid=1 for exactly one ce-enabled cycle. dout = clamp(acc_next, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1), and sat=1 iff clamping occurred. Otherwise out_valid=0, and dout/sat hold their last values.
- Latency: input beat with last at enabled cycle t gives out_valid at enabled cycle t+NUM_STAGE+1. Throughput is one pair per cycle with no back-pressure. Bubbles (in_valid=0) are allowed anywhere in a frame.
- ce=0: all registers, including out_valid, hold. A pulse present when ce falls remains visible until the next enabled cycle.
- Back-to-back frames are supported: a last on beat n followed by first on beat n+1 loses no data.

Optional Feature:
FC_MAC_RELU_EN. When defined, a ReLU is applied after saturation. A negative clamped result outputs 0, and sat reflects only the clamp, not the ReLU. When undefined, the signed saturated result is output unchanged. Latency is identical in both builds.

Decomposition:
- Package fc_mac_pkg holds the default width constants and a localparam function computing the saturation limits from OUT_WIDTH.
- Sub-module fc_mac_mul_pipe: NUM_STAGE-deep signed multiplier with a sideband (valid/first/last) shift register and ce. This structure is intended to map onto the DSP48 internal registers.
- The top level adds the accumulator, the saturation and the optional ReLU.

Test Plan:
- Single-term frame: din0=3, din1=-4, first=last=1 gives out_valid at t+4 (defaults), dout=-12, sat=0.
- Four-term frame with bubbles: products 100, 200, -50, 7, with in_valid low on two interior beats, gives dout=257 after the last beat plus latency.
- Saturation: 32768 (2^15) beats of din0=din1=-32768, each product 2^30, sum 2^45. This wraps the 40-bit acc to 0, giving dout=0, sat=0; with ACC_WIDTH=48 it gives dout=2147483647, sat=1. Also check 3 beats giving dout=2147483647, sat=1.
- Back-to-back frames: frame A {5*5} with last, then frame B {2*3, 1*1} on the very next beat, gives results 25 and 7 on consecutive out_valid pulses with no cross-contamination.
- ce stall and reset: hold ce=0 for 5 cycles mid-frame and the result value is unchanged, only delayed 5 cycles. Assert ap_rst_n=0 mid-frame and out_valid stays 0, and the next frame sums from zero.
- FC_MAC_RELU_EN build: a frame summing to -12 gives dout=0, sat=0; a frame summing to 9 gives dout=9.
